// File: rtl/mem_responder.sv
// Word-addressed data memory answering one load/store request at a time,
// with a fixed, parameterised latency between request acceptance and response.
module mem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             accept;
    logic             addr_err;
    logic [AW-1:0]    index;

    assign accept   = req_valid && req_ready;
    assign index    = req_addr[AW+1:2];
    assign addr_err = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= 32'(DEPTH));

    // Storage is deliberately left out of reset; a store accepted before reset stays written.
    always_ff @(posedge clk) begin
        if (accept && req_we && !addr_err) begin
            mem[index] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Load data is captured here so the response never changes while held.
                        req_ready  <= 1'b0;
                        cnt        <= 4'(LATENCY - 1);
                        resp_err   <= addr_err;
                        resp_rdata <= (addr_err || req_we) ? '0 : mem[index];
                        if (LATENCY > 1) begin
                            state <= WAIT;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=2 instance for the main traffic
// and a LATENCY=1 instance for back-to-back throughput.
module tb_mem_responder;

    logic        clk;
    logic        reset;

    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] req_addr1, req_wdata1, resp_rdata1;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sbq[$];
    exp_t        sbq1[$];
    logic [31:0] model [64];
    logic [31:0] model1 [64];
    int          n_chk  = 0;
    int          n_pass = 0;

    mem_responder #(.WIDTH(32), .DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.WIDTH(32), .DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd64);
    endfunction

    task automatic scramble();
        req_we    = 1'b1;
        req_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        req_wdata = $urandom;
    endtask

    // Drive one request, then hold resp_ready low for 'hold' cycles before consuming.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold);
        int          n;
        int          lat;
        exp_t        e;
        logic [31:0] held;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 64'(req_ready), 64'h1);
        e.err   = addr_bad(addr);
        e.rdata = (e.err || we) ? 32'h0 : model[addr[7:2]];
        if (we && !e.err) model[addr[7:2]] = wdata;
        sbq.push_back(e);
        @(negedge clk);
        scramble();
        lat = 1;
        while (!resp_valid && lat < 20) begin
            chk("wait_ready", 64'(req_ready), 64'h0);
            @(negedge clk);
            scramble();
            lat++;
        end
        chk("latency", 64'(lat), 64'd2);
        held = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            chk("hold_ready", 64'(req_ready), 64'h0);
            @(negedge clk);
            scramble();
            chk("hold_valid", 64'(resp_valid), 64'h1);
            chk("hold_rdata", 64'(resp_rdata), 64'(held));
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        chk("consume_ready", 64'(req_ready), 64'h0);
        chk("sb_size", 64'(sbq.size()), 64'd1);
        e = (sbq.size() > 0) ? sbq.pop_front() : '0;
        chk("rdata", 64'(resp_rdata), 64'(e.rdata));
        chk("err", 64'(resp_err), 64'(e.err));
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_valid", 64'(resp_valid), 64'h0);
        chk("post_rdata", 64'(resp_rdata), 64'h0);
        chk("post_err", 64'(resp_err), 64'h0);
        chk("post_ready", 64'(req_ready), 64'h1);
    endtask

    // Present a request and return once the accepting edge has passed.
    task automatic issue_only(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", 64'(req_ready), 64'h1);
        if (we && !addr_bad(addr)) model[addr[7:2]] = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    localparam int N1 = 7;
    logic        seq_we   [N1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] seq_addr [N1] = '{32'h0, 32'h4, 32'h4, 32'h0, 32'h6, 32'h104, 32'h0};
    logic [31:0] seq_data [N1] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0, 32'h0, 32'h0,
                                   32'hFFFF_FFFF, 32'h0};

    initial begin
        int   idx;
        int   last;
        int   n;
        bit   pend;
        exp_t e1;

        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; resp_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_valid", 64'(resp_valid), 64'h0);
        chk("rst_rdata", 64'(resp_rdata), 64'h0);
        chk("rst_err", 64'(resp_err), 64'h0);
        chk("rst_ready1", 64'(req_ready1), 64'h0);
        chk("rst_valid1", 64'(resp_valid1), 64'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'h1);

        for (int i = 0; i < 64; i++) do_req(1'b1, 32'(i * 4), $urandom, 0);

        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 32'h10, 32'h0, 0);
        do_req(1'b0, 32'h10, 32'h0, 5);

        do_req(1'b0, 32'h06, 32'h0, 0);
        do_req(1'b0, 32'h100, 32'h0, 1);
        do_req(1'b1, 32'h100, 32'hFFFF_FFFF, 0);
        do_req(1'b1, 32'hFFFF_FFFC, 32'h0BAD_0BAD, 0);
        do_req(1'b1, 32'h13, 32'h0BAD_F00D, 0);
        for (int i = 0; i < 64; i++) do_req(1'b0, 32'(i * 4), 32'h0, 0);

        // Reset while a store sits in WAIT: response dropped, store kept.
        issue_only(1'b1, 32'h20, 32'h1234_5678);
        reset = 1'b0;
        #1;
        chk("rst_wait_valid", 64'(resp_valid), 64'h0);
        chk("rst_wait_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        chk("rst_hold_ready", 64'(req_ready), 64'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rel_ready", 64'(req_ready), 64'h1);
        do_req(1'b0, 32'h20, 32'h0, 0);

        // Reset while a load response is being presented.
        issue_only(1'b0, 32'h10, 32'h0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("resp_pre_rst", 64'(resp_rdata), 64'hDEAD_BEEF);
        reset = 1'b0;
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_req(1'b0, 32'h10, 32'h0, 0);

        // Back-to-back traffic into the single-cycle-latency instance.
        idx = 0; last = -1; pend = 1'b0;
        resp_ready1 = 1'b1;
        req_we1 = seq_we[0]; req_addr1 = seq_addr[0]; req_wdata1 = seq_data[0];
        req_valid1 = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (pend) begin
                chk("l1_valid", 64'(resp_valid1), 64'h1);
                e1 = (sbq1.size() > 0) ? sbq1.pop_front() : '0;
                chk("l1_rdata", 64'(resp_rdata1), 64'(e1.rdata));
                chk("l1_err", 64'(resp_err1), 64'(e1.err));
                pend = 1'b0;
                if (idx < N1) begin
                    req_we1 = seq_we[idx]; req_addr1 = seq_addr[idx]; req_wdata1 = seq_data[idx];
                end else begin
                    req_valid1 = 1'b0;
                end
            end
            if (req_valid1 && req_ready1) begin
                chk("l1_idle_valid", 64'(resp_valid1), 64'h0);
                if (last >= 0) chk("l1_gap", 64'(cyc - last), 64'd2);
                last = cyc;
                e1.err   = addr_bad(req_addr1);
                e1.rdata = (e1.err || req_we1) ? 32'h0 : model1[req_addr1[7:2]];
                if (req_we1 && !e1.err) model1[req_addr1[7:2]] = req_wdata1;
                sbq1.push_back(e1);
                idx++;
                pend = 1'b1;
            end
        end
        chk("l1_count", 64'(idx), 64'(N1));
        chk("sb_drained", 64'(sbq.size() + sbq1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
